// File: rtl/stage_phase_accumulation_if.sv
// ----------------------------------------------------------------------------
// stage_phase_accumulation_if
// Bundles the configuration, slot-request and phase-output signals of
// stage_phase_accumulation. Signal names keep the accumulator's own point of
// view: i_* are driven into the accumulator and o_* are driven out of it.
//
//   i_ConfigWrite     write i_ConfigData into the step of i_ConfigOperator
//   i_ConfigOperator  operator whose phase step is written
//   i_ConfigData      unsigned phase step
//   i_Valid           slot request for i_OperatorNum
//   i_OperatorNum     operator served this slot
//   i_NoteOn          restart this operator's phase at 0
//   i_Modulation      signed FM offset added to the emitted phase
//   o_Ready           high once the power-up clear sweep has finished
//   o_Valid           o_Phase / o_OperatorNum are valid
//   o_OperatorNum     operator that o_Phase belongs to
//   o_Phase           signed phase word for the waveform stage
//
// Modports: master = operator sequencer / modulation routing side,
//           slave  = the phase accumulator.
// ----------------------------------------------------------------------------
interface stage_phase_accumulation_if #(
   parameter int NUM_OPERATORS = 32,
   parameter int STEP_WIDTH    = 20
);
   localparam int OP_WIDTH    = $clog2(NUM_OPERATORS);
   localparam int PHASE_WIDTH = 17;

   logic                          i_ConfigWrite;
   logic [OP_WIDTH-1:0]           i_ConfigOperator;
   logic [STEP_WIDTH-1:0]         i_ConfigData;
   logic                          i_Valid;
   logic [OP_WIDTH-1:0]           i_OperatorNum;
   logic                          i_NoteOn;
   logic signed [PHASE_WIDTH-1:0] i_Modulation;
   logic                          o_Ready;
   logic                          o_Valid;
   logic [OP_WIDTH-1:0]           o_OperatorNum;
   logic signed [PHASE_WIDTH-1:0] o_Phase;

   modport master (
      output i_ConfigWrite, i_ConfigOperator, i_ConfigData,
      output i_Valid, i_OperatorNum, i_NoteOn, i_Modulation,
      input  o_Ready, o_Valid, o_OperatorNum, o_Phase
   );

   modport slave (
      input  i_ConfigWrite, i_ConfigOperator, i_ConfigData,
      input  i_Valid, i_OperatorNum, i_NoteOn, i_Modulation,
      output o_Ready, o_Valid, o_OperatorNum, o_Phase
   );
endinterface

// File: rtl/stage_phase_accumulation.sv
// ----------------------------------------------------------------------------
// stage_phase_accumulation
// Time-multiplexed per-operator phase accumulator. One ACC_WIDTH accumulator
// and one STEP_WIDTH phase step are kept per operator. Every valid slot emits
// the operator's current (pre-update) phase plus a signed FM offset, two
// cycles after the request, and advances that operator's accumulator by its
// step. After reset a clear sweep zeroes both arrays, one operator per cycle,
// before o_Ready rises.
//
// Ports
//   i_Clock  clock, all logic on the rising edge
//   i_Reset  asynchronous, active-high reset
//   bus      stage_phase_accumulation_if.slave (config, slot request,
//            phase output and o_Ready; see the interface header)
// ----------------------------------------------------------------------------
module stage_phase_accumulation #(
   parameter int NUM_OPERATORS = 32,
   parameter int ACC_WIDTH     = 24,
   parameter int STEP_WIDTH    = 20
) (
   input  logic                         i_Clock,
   input  logic                         i_Reset,
   stage_phase_accumulation_if.slave    bus
);
   localparam int OP_WIDTH    = $clog2(NUM_OPERATORS);
   localparam int PHASE_WIDTH = 17;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   state_t                  state;
   state_t                  state_next;
   logic [OP_WIDTH-1:0]     clear_cnt;
   logic                    clear_en;
   logic                    ready;

   logic [ACC_WIDTH-1:0]    acc_mem  [NUM_OPERATORS];
   logic [STEP_WIDTH-1:0]   step_mem [NUM_OPERATORS];

   // Stage 1 registers (slot accepted, operands read)
   logic                    s1_valid;
   logic [OP_WIDTH-1:0]     s1_op;
   logic                    s1_note;
   logic [PHASE_WIDTH-1:0]  s1_mod;
   logic [ACC_WIDTH-1:0]    s1_acc;
   logic [STEP_WIDTH-1:0]   s1_step;

   logic                    slot_accept;
   logic                    cfg_accept;
   logic [ACC_WIDTH-1:0]    rd_acc;
   logic [ACC_WIDTH-1:0]    wb_acc;
   logic [PHASE_WIDTH-1:0]  phase_base;
   logic [PHASE_WIDTH-1:0]  emit_phase;

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   // NOTE: clocked state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process evaluation order.
   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) state <= ST_CLEAR;
      else         state <= state_next;
   end

   // FSM: next state. RUN is only left through i_Reset.
   // NOTE: every combinationally written signal gets a default first so no
   // path through the block leaves it unassigned and infers a latch.
   always_comb begin
      state_next = state;
      case (state)
         ST_CLEAR: if (clear_cnt == OP_WIDTH'(NUM_OPERATORS - 1)) state_next = ST_RUN;
         ST_RUN:   state_next = ST_RUN;
         default:  state_next = ST_CLEAR;
      endcase
   end

   // FSM: outputs
   always_comb begin
      clear_en = 1'b0;
      ready    = 1'b0;
      case (state)
         ST_CLEAR: clear_en = 1'b1;
         ST_RUN:   ready    = 1'b1;
         default:  clear_en = 1'b1;
      endcase
   end

   assign bus.o_Ready = ready;

   // Sweep counter walks every operator exactly once after reset.
   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset)       clear_cnt <= '0;
      else if (clear_en) clear_cnt <= clear_cnt + 1'b1;
   end

   // Requests and config writes are ignored until the sweep is done.
   assign slot_accept = bus.i_Valid       && ready;
   assign cfg_accept  = bus.i_ConfigWrite && ready;

   // ------------------------------------------------------------------------
   // Stage 1: operand read. When stage 2 is writing back the same operator
   // this cycle, take the write-back value so back-to-back slots of one
   // operator behave exactly like slots spaced apart.
   // ------------------------------------------------------------------------
   assign rd_acc = (s1_valid && (s1_op == bus.i_OperatorNum)) ? wb_acc
                                                              : acc_mem[bus.i_OperatorNum];

   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         s1_valid <= 1'b0;
         s1_op    <= '0;
         s1_note  <= 1'b0;
         s1_mod   <= '0;
         s1_acc   <= '0;
         s1_step  <= '0;
      end else begin
         s1_valid <= slot_accept;
         s1_op    <= bus.i_OperatorNum;
         s1_note  <= bus.i_NoteOn;
         s1_mod   <= bus.i_Modulation;
         s1_acc   <= rd_acc;
         s1_step  <= step_mem[bus.i_OperatorNum];
      end
   end

   // ------------------------------------------------------------------------
   // Stage 2: emit the pre-update phase and compute the write-back value.
   // Both sums wrap silently at their widths.
   // ------------------------------------------------------------------------
   assign wb_acc     = s1_note ? ACC_WIDTH'(s1_step) : s1_acc + ACC_WIDTH'(s1_step);
   assign phase_base = s1_note ? '0 : s1_acc[ACC_WIDTH-1 -: PHASE_WIDTH];
   assign emit_phase = phase_base + s1_mod;

   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         bus.o_Valid       <= 1'b0;
         bus.o_OperatorNum <= '0;
         bus.o_Phase       <= '0;
      end else begin
         bus.o_Valid <= s1_valid;
         if (s1_valid) begin
            bus.o_OperatorNum <= s1_op;
            bus.o_Phase       <= emit_phase;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Storage arrays. The clear sweep owns both arrays; afterwards the
   // accumulator array is written only by stage 2 and the step array only by
   // config writes, so the two writers never collide.
   // ------------------------------------------------------------------------
   // NOTE: the arrays carry no reset term so they map onto plain RAM/regfile
   // cells; the post-reset sweep is what zeroes them.
   always_ff @(posedge i_Clock) begin
      if (clear_en) begin
         acc_mem[clear_cnt]  <= '0;
         step_mem[clear_cnt] <= '0;
      end else begin
         if (s1_valid)   acc_mem[s1_op]                 <= wb_acc;
         if (cfg_accept) step_mem[bus.i_ConfigOperator] <= bus.i_ConfigData;
      end
   end

endmodule
